// File: rtl/regfile_debug_port.sv
// Debug initiator for the register file: DUMP streams a register range out over
// valid/ready, LOAD writes a valid/ready input stream into a register range.
module regfile_debug_port #(
    parameter int NUM_REGISTERS = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SKIP_ZERO     = 1,
    parameter int ADDR_WIDTH    = $clog2(NUM_REGISTERS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_start_i,
    input  logic [ADDR_WIDTH:0]   cmd_count_i,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  rf_we_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  busy_o,
    output logic                  done_o
);

    // state    | meaning
    // IDLE     | waiting for a command, cmd_ready high
    // DUMP_RD  | capture rf_rdata at addr into the output register
    // DUMP_OUT | hold the output word until the consumer takes it
    // LOAD     | accept input words, one register write per handshake
    // DONE     | one-cycle completion pulse, then back to IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_LOAD,
        S_DONE
    } state_t;

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] NUM_REGS_C = CW'(NUM_REGISTERS);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CW-1:0]           rem_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [ADDR_WIDTH-1:0]   out_addr_q;
    logic                    rf_we_q;
    logic [ADDR_WIDTH-1:0]   rf_waddr_q;
    logic [DATA_WIDTH-1:0]   rf_wdata_q;
    logic                    done_q;

    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [CW-1:0]           rem_d;
    logic [CW-1:0]           count_clamped;
    logic                    last_xfer;

    // Power-of-two register count makes the natural overflow the wrap.
    assign addr_d        = addr_q + ADDR_WIDTH'(1);
    assign rem_d         = rem_q - CW'(1);
    assign last_xfer     = (rem_q == CW'(1));
    assign count_clamped = (cmd_count_i > NUM_REGS_C) ? NUM_REGS_C : cmd_count_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            rf_we_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q <= cmd_start_i;
                        rem_q  <= count_clamped;
                        if (count_clamped == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= cmd_op_i ? S_LOAD : S_DUMP_RD;
                        end
                    end
                end
                S_DUMP_RD: begin
                    out_data_q  <= rf_rdata_i;
                    out_addr_q  <= addr_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DUMP_OUT;
                end
                S_DUMP_OUT: begin
                    if (out_valid_q && out_ready_i) begin
                        out_valid_q <= 1'b0;
                        addr_q      <= addr_d;
                        rem_q       <= rem_d;
                        if (last_xfer) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DUMP_RD;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid_i) begin
                        rf_waddr_q <= addr_q;
                        rf_wdata_q <= in_data_i;
                        // Register 0 is hardwired in the core; the word is still consumed.
                        rf_we_q    <= !((SKIP_ZERO != 0) && (addr_q == '0));
                        addr_q     <= addr_d;
                        rem_q      <= rem_d;
                        if (last_xfer) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign in_ready_o  = (state_q == S_LOAD);
    assign busy_o      = (state_q != S_IDLE);
    assign rf_raddr_o  = addr_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign rf_we_o     = rf_we_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_addr_o  = out_addr_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Directed bench for regfile_debug_port with a behavioural register file
// and monitors that log every DUMP handshake and every register write.
module tb_regfile_debug_port;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_op_i;
    logic [AW-1:0] cmd_start_i;
    logic [AW:0]   cmd_count_i;
    logic [AW-1:0] rf_raddr_o;
    logic [DW-1:0] rf_rdata_i;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic          rf_we_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [AW-1:0] out_addr_o;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          busy_o;
    logic          done_o;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]    mem [32];
    logic [AW+DW-1:0] out_q [$];
    logic [AW+DW-1:0] we_q  [$];

    always #5 clk_i = ~clk_i;

    regfile_debug_port dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_start_i (cmd_start_i),
        .cmd_count_i (cmd_count_i),
        .rf_raddr_o  (rf_raddr_o),
        .rf_rdata_i  (rf_rdata_i),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .rf_we_o     (rf_we_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_addr_o  (out_addr_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    assign rf_rdata_i = mem[rf_raddr_o];

    always @(posedge clk_i) begin
        if (rf_we_o) begin
            mem[rf_waddr_o] <= rf_wdata_o;
            we_q.push_back({rf_waddr_o, rf_wdata_o});
        end
        if (out_valid_o && out_ready_i && !rst_i)
            out_q.push_back({out_addr_o, out_data_o});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic op, input logic [AW-1:0] start, input logic [AW:0] count);
        cmd_op_i    = op;
        cmd_start_i = start;
        cmd_count_i = count;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!done_o && n < limit) begin
            tick();
            n++;
        end
        check(tag, {63'd0, done_o}, 64'd1);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
        mem[4] = 32'hA; mem[5] = 32'hB; mem[6] = 32'hC;
        mem[8] = 32'h55; mem[9] = 32'h66;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 1'b0; cmd_start_i = '0;
        cmd_count_i = '0; out_ready_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
        tick(); tick();
        rst_i = 1'b0;

        // reset state
        check("rst_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_outs", {out_valid_o, rf_we_o, done_o, out_data_o, out_addr_o, rf_waddr_o},
              64'd0);

        // DUMP start=4 count=3, consumer always ready
        out_ready_i = 1'b1;
        issue(1'b0, 5'd4, 6'd3);
        check("d1_t1_busy", {62'd0, busy_o, cmd_ready_o}, 64'd2);
        check("d1_t1_valid", {63'd0, out_valid_o}, 64'd0);
        tick();
        check("d1_t2_word", {out_valid_o, out_addr_o, out_data_o}, {1'b1, 5'd4, 32'hA});
        tick();
        check("d1_t3_valid", {63'd0, out_valid_o}, 64'd0);
        tick();
        check("d1_t4_word", {out_valid_o, out_addr_o, out_data_o}, {1'b1, 5'd5, 32'hB});
        tick(); tick();
        check("d1_t6_word", {out_valid_o, out_addr_o, out_data_o}, {1'b1, 5'd6, 32'hC});
        tick();
        check("d1_t7_done", {62'd0, done_o, busy_o}, 64'd3);
        tick();
        check("d1_t8_idle", {61'd0, done_o, busy_o, cmd_ready_o}, 64'd1);
        check("d1_count", out_q.size(), 64'd3);

        // DUMP with backpressure; source changes under a held word
        out_q.delete();
        out_ready_i = 1'b0;
        issue(1'b0, 5'd8, 6'd2);
        tick();
        mem[8] = 32'hDEAD;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {out_valid_o, out_addr_o, out_data_o}, {1'b1, 5'd8, 32'h55});
            tick();
        end
        out_ready_i = 1'b1;
        wait_done("bp_done", 20);
        check("bp_count", out_q.size(), 64'd2);
        check("bp_w0", out_q[0], {5'd8, 32'h55});
        check("bp_w1", out_q[1], {5'd9, 32'h66});

        // LOAD start=30 count=4 with wrap; register 0 skipped
        we_q.delete();
        mem[0] = 32'h0; mem[1] = 32'h0; mem[30] = 32'h0; mem[31] = 32'h0;
        issue(1'b1, 5'd30, 6'd4);
        check("ld_in_ready", {63'd0, in_ready_o}, 64'd1);
        in_valid_i = 1'b1;
        in_data_i = 32'h11; tick();
        check("ld_we30", {rf_we_o, rf_waddr_o, rf_wdata_o}, {1'b1, 5'd30, 32'h11});
        in_data_i = 32'h22; tick();
        in_data_i = 32'h33; tick();
        check("ld_skip0", {63'd0, rf_we_o}, 64'd0);
        in_data_i = 32'h44; tick();
        in_valid_i = 1'b0;
        check("ld_last", {rf_we_o, done_o, in_ready_o, rf_waddr_o, rf_wdata_o},
              {1'b1, 1'b1, 1'b0, 5'd1, 32'h44});
        tick();
        check("ld_we_count", we_q.size(), 64'd3);
        check("ld_we31", we_q[1], {5'd31, 32'h22});
        check("ld_mem0", mem[0], 64'd0);
        check("ld_mem1", mem[1], 64'h44);

        // zero-length commands
        out_q.delete(); we_q.delete();
        issue(1'b0, 5'd3, 6'd0);
        check("z_done_t1", {62'd0, done_o, busy_o}, 64'd3);
        tick();
        in_valid_i = 1'b1;
        issue(1'b1, 5'd3, 6'd0);
        check("z_ld_done_t1", {61'd0, done_o, in_ready_o, busy_o}, 64'd5);
        tick(); tick();
        in_valid_i = 1'b0;
        check("z_no_xfer", {32'd0, out_q.size(), we_q.size()}, 64'd0);

        // oversize count clamps to the register count
        out_q.delete();
        issue(1'b0, 5'd5, 6'd40);
        wait_done("big_done", 200);
        check("big_count", out_q.size(), 64'd32);
        check("big_first", {59'd0, out_q[0][AW+DW-1:DW]}, 64'd5);
        check("big_last", {59'd0, out_q[31][AW+DW-1:DW]}, 64'd4);

        // reset on the second LOAD handshake
        we_q.delete();
        mem[10] = 32'h0; mem[11] = 32'h0;
        issue(1'b1, 5'd10, 6'd3);
        in_valid_i = 1'b1;
        in_data_i = 32'h77; tick();
        in_data_i = 32'h88; rst_i = 1'b1; tick();
        rst_i = 1'b0;
        check("ra_state", {59'd0, rf_we_o, in_ready_o, cmd_ready_o, busy_o, done_o},
              64'b00100);
        in_valid_i = 1'b0;
        tick();
        check("ra_mem10", mem[10], 64'h77);
        check("ra_mem11", mem[11], 64'h0);
        check("ra_we_count", we_q.size(), 64'd1);

        // cmd_valid held through a command
        out_q.delete();
        out_ready_i = 1'b1;
        cmd_op_i = 1'b0; cmd_start_i = 5'd4; cmd_count_i = 6'd1; cmd_valid_i = 1'b1;
        tick();
        check("hold_t1_ready", {63'd0, cmd_ready_o}, 64'd0);
        tick();
        cmd_start_i = 5'd6;
        tick();
        check("hold_t3_done", {62'd0, done_o, cmd_ready_o}, 64'd2);
        tick();
        check("hold_t4_ready", {63'd0, cmd_ready_o}, 64'd1);
        tick();
        cmd_valid_i = 1'b0;
        check("hold_t5_busy", {63'd0, busy_o}, 64'd1);
        tick();
        check("hold_t6_word", {out_valid_o, out_addr_o, out_data_o}, {1'b1, 5'd6, 32'hC});
        wait_done("hold_done", 20);
        tick();
        check("hold_count", out_q.size(), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
